// File: rtl/radix4_mul_arbiter_pkg.sv
// radix4_mul_arbiter_pkg: shared FSM encoding and default widths for the multiplier arbiter
package radix4_pkg;
  localparam int W_DEF = 8;
  localparam int PW_DEF = 2 * W_DEF;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/radix4_mul_arbiter_if.sv
// radix4_mul_arbiter_if: requester handshake plus multiplier go/done bus
interface radix4_mul_arbiter_if
  import radix4_pkg::*;
#(
  parameter int N = 4,
  parameter int W = W_DEF
);
  logic [N-1:0]   req;
  logic [N*W-1:0] opa_flat;
  logic [N*W-1:0] opb_flat;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [2*W-1:0] rsp_data;
  logic           rsp_err;
  logic           busy;
  logic           mul_go;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_p;
  modport slave (
    input  req, opa_flat, opb_flat, mul_done, mul_p,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, mul_go, mul_a, mul_b
  );
  modport master (
    output req, opa_flat, opb_flat, mul_done, mul_p,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, mul_go, mul_a, mul_b
  );
endinterface

// File: rtl/radix4_mul_arbiter_rr_pick.sv
// rr_pick: first set request scanning upward from ptr with wrap, as one-hot and index
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW:0] s;
  always_comb begin
    onehot = '0;
    idx = '0;
    any = 1'b0;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr} + (IW+1)'(i);
      s = s >= (IW+1)'(N) ? s - (IW+1)'(N) : s;
      if (!any && req[s[IW-1:0]]) begin
        any = 1'b1;
        idx = s[IW-1:0];
        onehot[s[IW-1:0]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/radix4_mul_arbiter.sv
// radix4_mul_arbiter: round-robin sharing of one go/done multiplier among N requesters with timeout
module radix4_mul_arbiter
  import radix4_pkg::*;
#(
  parameter int N           = 4,
  parameter int W           = W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input logic clk,
  input logic rst,
  radix4_mul_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT_CYC);
  state_t state, nxt;
  logic [N-1:0] pick;
  logic [IW-1:0] pick_idx, win, rr_ptr;
  logic any, tmo;
  logic [CW-1:0] cnt;
  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req(bus.req), .ptr(rr_ptr), .onehot(pick), .idx(pick_idx), .any(any)
  );
  assign tmo = cnt == CW'(TIMEOUT_CYC - 1);
  assign bus.mul_go = state == ST_ISSUE;
  assign bus.busy = state != ST_IDLE;
  assign bus.rsp_valid = state == ST_RESP ? bus.gnt : '0;
  always_comb begin
    nxt = state;
    nxt = state == ST_IDLE  ? (any ? ST_ISSUE : ST_IDLE) :
          state == ST_ISSUE ? ST_WAIT :
          state == ST_WAIT  ? (bus.mul_done || tmo ? ST_RESP : ST_WAIT) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      bus.gnt <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err <= 1'b0;
      bus.mul_a <= '0;
      bus.mul_b <= '0;
      rr_ptr <= '0;
      win <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && any) begin
        bus.gnt <= pick;
        win <= pick_idx;
        bus.mul_a <= bus.opa_flat[pick_idx*W +: W];
        bus.mul_b <= bus.opb_flat[pick_idx*W +: W];
      end
      if (state == ST_ISSUE) cnt <= '0;
      if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
        // done takes priority over a coincident timeout
        if (bus.mul_done || tmo) begin
          bus.rsp_data <= bus.mul_done ? bus.mul_p : '0;
          bus.rsp_err <= !bus.mul_done;
        end
      end
      if (state == ST_RESP) begin
        bus.gnt <= '0;
        rr_ptr <= win == IW'(N - 1) ? '0 : win + 1'b1;
      end
    end
  end
endmodule
